// File: rtl/bsg_fpu_cmp_pkg.sv
// Shared types and constants for the FP16 compare / min-max pipeline.
// The FCLASS option (BSG_FPU_CMP_FCLASS_EN) reuses the class bit indices below.
package bsg_fpu_cmp_pkg;

    localparam int unsigned FP_W  = 16;
    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;

    localparam logic [FP_W-1:0] QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        OP_FEQ    = 3'd0,
        OP_FLT    = 3'd1,
        OP_FLE    = 3'd2,
        OP_FMIN   = 3'd3,
        OP_FMAX   = 3'd4,
        OP_FCLASS = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    // RISC-V fclass one-hot bit positions
    localparam logic [3:0] FC_NEG_INF  = 4'd0;
    localparam logic [3:0] FC_NEG_NORM = 4'd1;
    localparam logic [3:0] FC_NEG_SUB  = 4'd2;
    localparam logic [3:0] FC_NEG_ZERO = 4'd3;
    localparam logic [3:0] FC_POS_ZERO = 4'd4;
    localparam logic [3:0] FC_POS_SUB  = 4'd5;
    localparam logic [3:0] FC_POS_NORM = 4'd6;
    localparam logic [3:0] FC_POS_INF  = 4'd7;
    localparam logic [3:0] FC_SNAN     = 4'd8;
    localparam logic [3:0] FC_QNAN     = 4'd9;

    typedef struct packed {
        logic             zero;
        logic             nan;
        logic             snan;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } cls_t;

endpackage

// File: rtl/bsg_fpu_preprocess.sv
// Combinational FP16 operand classifier feeding the compare pipeline.
// Infinity/denormal outputs exist only when BSG_FPU_CMP_FCLASS_EN is defined.
module bsg_fpu_preprocess
    import bsg_fpu_cmp_pkg::*;
(
    input  logic [FP_W-1:0]  i_a,
    output logic             o_zero_c,
    output logic             o_nan_c,
    output logic             o_snan_c,
    output logic             o_sign_c,
    output logic [EXP_W-1:0] o_exp_c,
    output logic [MAN_W-1:0] o_man_c
`ifdef BSG_FPU_CMP_FCLASS_EN
    ,
    output logic             o_inf_c,
    output logic             o_denorm_c
`endif
);

    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_zero;

    assign o_sign_c   = i_a[FP_W-1];
    assign o_exp_c    = i_a[FP_W-2 -: EXP_W];
    assign o_man_c    = i_a[MAN_W-1:0];
    assign w_exp_ones = &o_exp_c;
    assign w_exp_zero = ~|o_exp_c;
    assign w_man_zero = ~|o_man_c;

    assign o_zero_c = w_exp_zero & w_man_zero;
    assign o_nan_c  = w_exp_ones & ~w_man_zero;
    // quiet bit is the mantissa MSB
    assign o_snan_c = o_nan_c & ~o_man_c[MAN_W-1];

`ifdef BSG_FPU_CMP_FCLASS_EN
    assign o_inf_c    = w_exp_ones & w_man_zero;
    assign o_denorm_c = w_exp_zero & ~w_man_zero;
`endif

endmodule

// File: rtl/bsg_fpu_cmp_pipe.sv
// Two-stage FP16 compare / minNum / maxNum unit with valid-ready in, valid-yumi out.
// Defining BSG_FPU_CMP_FCLASS_EN adds op 5 = FCLASS on operand A.
module bsg_fpu_cmp_pipe
    import bsg_fpu_cmp_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            v_i,
    output logic            ready_o,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic            v_o,
    input  logic            yumi_i,
    output logic [FP_W-1:0] data_o,
    output logic            invalid_o
);

    cls_t w_a_cls, w_b_cls;
    cls_t r_s1_a_cls, r_s1_b_cls;
    logic [FP_W-1:0] r_s1_a, r_s1_b;
    op_e  r_s1_op;
    logic r_s1_v, r_s2_v;
    logic [FP_W-1:0] r_data;
    logic r_invalid;
    logic w_s2_adv;

`ifdef BSG_FPU_CMP_FCLASS_EN
    logic w_a_inf, w_a_denorm, w_b_inf, w_b_denorm;
    logic r_s1_a_inf, r_s1_a_denorm;
`endif

    bsg_fpu_preprocess u_pre_a (
        .i_a      (a_i),
        .o_zero_c (w_a_cls.zero),
        .o_nan_c  (w_a_cls.nan),
        .o_snan_c (w_a_cls.snan),
        .o_sign_c (w_a_cls.sign),
        .o_exp_c  (w_a_cls.exp),
        .o_man_c  (w_a_cls.man)
`ifdef BSG_FPU_CMP_FCLASS_EN
        ,
        .o_inf_c    (w_a_inf),
        .o_denorm_c (w_a_denorm)
`endif
    );

    bsg_fpu_preprocess u_pre_b (
        .i_a      (b_i),
        .o_zero_c (w_b_cls.zero),
        .o_nan_c  (w_b_cls.nan),
        .o_snan_c (w_b_cls.snan),
        .o_sign_c (w_b_cls.sign),
        .o_exp_c  (w_b_cls.exp),
        .o_man_c  (w_b_cls.man)
`ifdef BSG_FPU_CMP_FCLASS_EN
        ,
        .o_inf_c    (w_b_inf),
        .o_denorm_c (w_b_denorm)
`endif
    );

    assign w_s2_adv  = ~r_s2_v | yumi_i;
    assign ready_o   = ~r_s1_v | w_s2_adv;
    assign v_o       = r_s2_v;
    assign data_o    = r_data;
    assign invalid_o = r_invalid;

    // Stage 1 operand/class capture, only on an accepted input
    always_ff @(posedge clk_i) begin
        if (ready_o & v_i) begin
            r_s1_a_cls <= w_a_cls;
            r_s1_b_cls <= w_b_cls;
            r_s1_a     <= a_i;
            r_s1_b     <= b_i;
            r_s1_op    <= op_e'(op_i);
`ifdef BSG_FPU_CMP_FCLASS_EN
            r_s1_a_inf    <= w_a_inf;
            r_s1_a_denorm <= w_a_denorm;
`endif
        end
    end

    logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
    logic w_mag_lt, w_mag_gt;
    logic w_any_nan, w_any_snan, w_both_zero;
    logic w_lt_tot, w_lt, w_eq;
    logic [FP_W-1:0] w_min, w_max;
    logic [FP_W-1:0] w_data;
    logic w_invalid;

    assign w_mag_a     = {r_s1_a_cls.exp, r_s1_a_cls.man};
    assign w_mag_b     = {r_s1_b_cls.exp, r_s1_b_cls.man};
    assign w_mag_lt    = w_mag_a < w_mag_b;
    assign w_mag_gt    = w_mag_a > w_mag_b;
    assign w_any_nan   = r_s1_a_cls.nan | r_s1_b_cls.nan;
    assign w_any_snan  = r_s1_a_cls.snan | r_s1_b_cls.snan;
    assign w_both_zero = r_s1_a_cls.zero & r_s1_b_cls.zero;

    // Total order with -0 < +0; the IEEE relations then exclude the zero pair
    assign w_lt_tot = (r_s1_a_cls.sign != r_s1_b_cls.sign) ? r_s1_a_cls.sign :
                      (r_s1_a_cls.sign ? w_mag_gt : w_mag_lt);
    assign w_lt     = w_lt_tot & ~w_both_zero;
    assign w_eq     = (r_s1_a == r_s1_b) | w_both_zero;

    assign w_min = (r_s1_a_cls.nan & r_s1_b_cls.nan) ? QNAN :
                   r_s1_a_cls.nan ? r_s1_b :
                   r_s1_b_cls.nan ? r_s1_a :
                   (w_lt_tot ? r_s1_a : r_s1_b);
    assign w_max = (r_s1_a_cls.nan & r_s1_b_cls.nan) ? QNAN :
                   r_s1_a_cls.nan ? r_s1_b :
                   r_s1_b_cls.nan ? r_s1_a :
                   (w_lt_tot ? r_s1_b : r_s1_a);

    always_comb begin
        w_data    = '0;
        w_invalid = 1'b0;
        case (r_s1_op)
            OP_FEQ: begin
                w_data[0] = w_eq & ~w_any_nan;
                w_invalid = w_any_snan;
            end
            OP_FLT: begin
                w_data[0] = w_lt & ~w_any_nan;
                w_invalid = w_any_nan;
            end
            OP_FLE: begin
                w_data[0] = (w_lt | w_eq) & ~w_any_nan;
                w_invalid = w_any_nan;
            end
            OP_FMIN: begin
                w_data    = w_min;
                w_invalid = w_any_snan;
            end
            OP_FMAX: begin
                w_data    = w_max;
                w_invalid = w_any_snan;
            end
`ifdef BSG_FPU_CMP_FCLASS_EN
            OP_FCLASS: begin
                w_data[FC_SNAN]     = r_s1_a_cls.snan;
                w_data[FC_QNAN]     = r_s1_a_cls.nan & ~r_s1_a_cls.snan;
                w_data[FC_NEG_INF]  = r_s1_a_inf & r_s1_a_cls.sign;
                w_data[FC_POS_INF]  = r_s1_a_inf & ~r_s1_a_cls.sign;
                w_data[FC_NEG_ZERO] = r_s1_a_cls.zero & r_s1_a_cls.sign;
                w_data[FC_POS_ZERO] = r_s1_a_cls.zero & ~r_s1_a_cls.sign;
                w_data[FC_NEG_SUB]  = r_s1_a_denorm & r_s1_a_cls.sign;
                w_data[FC_POS_SUB]  = r_s1_a_denorm & ~r_s1_a_cls.sign;
                w_data[FC_NEG_NORM] = ~(r_s1_a_cls.nan | r_s1_a_inf | r_s1_a_cls.zero | r_s1_a_denorm) & r_s1_a_cls.sign;
                w_data[FC_POS_NORM] = ~(r_s1_a_cls.nan | r_s1_a_inf | r_s1_a_cls.zero | r_s1_a_denorm) & ~r_s1_a_cls.sign;
            end
`endif
            default: begin
                w_data    = '0;
                w_invalid = 1'b0;
            end
        endcase
    end

    // Valid bits and stage-2 result registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_data    <= '0;
            r_invalid <= 1'b0;
        end else begin
            if (ready_o) begin
                r_s1_v <= v_i;
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_data    <= w_data;
                    r_invalid <= w_invalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_fpu_cmp_pipe.sv
// Scoreboard bench for bsg_fpu_cmp_pipe: directed cases, streaming, stall, reset and random traffic.
module tb_bsg_fpu_cmp_pipe;

    logic        clk = 1'b0;
    logic        reset_i, v_i, ready_o, yumi_i, v_o, invalid_o;
    logic [15:0] a_i, b_i, data_o;
    logic [2:0]  op_i;

    bsg_fpu_cmp_pipe dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .op_i      (op_i),
        .v_o       (v_o),
        .yumi_i    (yumi_i),
        .data_o    (data_o),
        .invalid_o (invalid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        inv;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: value scaled by 2^24 as a signed integer
    function automatic longint fkey(input logic [15:0] x);
        longint mag;
        int     e;
        e = int'(x[14:10]);
        if (e == 31)     mag = longint'(1) <<< 45;
        else if (e == 0) mag = longint'(x[9:0]);
        else             mag = longint'(1024 + int'(x[9:0])) <<< (e - 1);
        return x[15] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic bit is_snan(input logic [15:0] x);
        return is_nan(x) && !x[9];
    endfunction

    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        logic        inv;
        bit          na, nb;
        longint      ka, kb;
        na = is_nan(a); nb = is_nan(b);
        ka = fkey(a);   kb = fkey(b);
        d = 16'h0; inv = 1'b0;
        case (op)
            3'd0: begin d[0] = !na && !nb && (ka == kb); inv = is_snan(a) || is_snan(b); end
            3'd1: begin d[0] = !na && !nb && (ka < kb);  inv = na || nb; end
            3'd2: begin d[0] = !na && !nb && (ka <= kb); inv = na || nb; end
            3'd3, 3'd4: begin
                inv = is_snan(a) || is_snan(b);
                if (na && nb)      d = 16'h7E00;
                else if (na)       d = b;
                else if (nb)       d = a;
                else if (ka != kb) d = ((ka < kb) == (op == 3'd3)) ? a : b;
                else if (a[15] != b[15]) d = ((op == 3'd3) == a[15]) ? a : b;
                else               d = a;
            end
`ifdef BSG_FPU_CMP_FCLASS_EN
            3'd5: begin
                int idx;
                if (na)                    idx = is_snan(a) ? 8 : 9;
                else if (a[14:10] == 5'h1F) idx = a[15] ? 0 : 7;
                else if (a[14:0] == 15'd0) idx = a[15] ? 3 : 4;
                else if (a[14:10] == 5'd0) idx = a[15] ? 2 : 5;
                else                       idx = a[15] ? 1 : 6;
                d = 16'd1 << idx;
            end
`endif
            default: begin d = 16'h0; inv = 1'b0; end
        endcase
        return {inv, d};
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] sp[14] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h4000, 16'h7C00, 16'hFC00,
                                16'h7E00, 16'h7C01, 16'hFE00, 16'h0001, 16'h8001, 16'h03FF, 16'h7BFF};
        if ($urandom_range(0, 1) == 1) return sp[$urandom_range(0, 13)];
        return 16'($urandom);
    endfunction

    // One cycle of stimulus; accepted ops go to the scoreboard
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input bit yum);
        logic [16:0] m;
        @(negedge clk);
        v_i = v; a_i = a; b_i = b; op_i = op;
        yumi_i = yum & v_o;
        #1;
        if (!reset_i && v_i && ready_o) begin
            m = model(op, a, b);
            sbq.push_back('{d: m[15:0], inv: m[16], cyc: cyc});
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40; i++) begin
            if (sbq.size() == 0 && !v_o) break;
            drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
        end
        if (i == 40) check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: compares every consumed result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_i && v_o && yumi_i) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("data", 32'(data_o), 32'(e.d));
                    check("invalid", 32'(invalid_o), 32'(e.inv));
                    if (lat_chk) check("latency", 32'(cyc), 32'(e.cyc + 2));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam int N_DIR = 11;
    logic [15:0] da[N_DIR] = '{16'h3C00, 16'h4000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                               16'h7E00, 16'h7E00, 16'h7C01, 16'h7E00, 16'hBC00};
    logic [15:0] db[N_DIR] = '{16'h4000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h3C00, 16'h3C00, 16'h3C00, 16'h7C01, 16'h3C00};
    logic [2:0]  dop[N_DIR] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3, 3'd4, 3'd6};

    initial begin
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        a_i = 16'h0; b_i = 16'h0; op_i = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_invalid", 32'(invalid_o), 32'd0);

        // Directed cases streamed back to back with yumi held high
        lat_chk = 1'b1;
        for (int i = 0; i < N_DIR; i++) begin
            drive(1'b1, da[i], db[i], dop[i], 1'b1);
            check("stream_ready", 32'(ready_o), 32'd1);
        end
`ifdef BSG_FPU_CMP_FCLASS_EN
        drive(1'b1, 16'hFC00, 16'h0, 3'd5, 1'b1);
        drive(1'b1, 16'h0001, 16'h0, 3'd5, 1'b1);
`endif
        drain();
        lat_chk = 1'b0;

        // Backpressure: fill both stages then stall for 4 cycles
        drive(1'b1, 16'h3C00, 16'h4000, 3'd1, 1'b0);
        drive(1'b1, 16'h4000, 16'h3C00, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pick(), pick(), 3'd3, 1'b0);
            check("stall_ready", 32'(ready_o), 32'd0);
            check("stall_v_o", 32'(v_o), 32'd1);
            check("stall_data", 32'(data_o), 32'h0001);
        end
        drain();

        // Reset with two operations in flight
        drive(1'b1, 16'h3C00, 16'h4000, 3'd4, 1'b0);
        drive(1'b1, 16'hBC00, 16'h4000, 3'd3, 1'b0);
        @(negedge clk);
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        sbq.delete();
        #1;
        check("midreset_v_o", 32'(v_o), 32'd0);
        check("midreset_ready", 32'(ready_o), 32'd1);
        check("midreset_data", 32'(data_o), 32'd0);
        repeat (6) drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);

        // Random traffic with random valid and yumi
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) < 7, pick(), pick(), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 7);
        end
        drain();
        check("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
